// File: rtl/simon_game_ctrl.sv
// simon_game_ctrl: Simon Says game sequencer driving the fsm side of the fsm_sig bundle.
// Steps through seeding, colour playback, player input and result checking. Rounds to win,
// speed range, ramp interval and the input timeout are parameters.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   go              start/restart strobe (accepted in IDLE, WIN, LOSE)
//   btn_press       player pressed a colour (accepted in PLAYER)
//   pulse           flash_timer tick (used in SHOW and PLAYER)
//   result[_valid]  check outcome, 1 = correct (accepted in CHECK)
//   start           rng replay strobe
//   load_colour     segments load strobe
//   load_speed      flash_timer speed load strobe
//   rst_seedgen     reg8 seed reset strobe
//   player_turn     high while awaiting or checking input
//   flash_clk       LED flash phase
//   check_round     element number during SHOW, current round during PLAYER/CHECK, else 0
//   speed           current speed code
//   win, lose       game outcome, held until the next go
module simon_game_ctrl #(
    parameter int unsigned MAX_ROUNDS     = 32,
    parameter int unsigned SPEED_W        = 3,
    parameter int unsigned SPEED_START    = 0,
    parameter int unsigned RAMP_EVERY     = 4,
    parameter int unsigned TIMEOUT_PULSES = 16,
    localparam int unsigned RW            = $clog2(MAX_ROUNDS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               go,
    input  logic               btn_press,
    input  logic               pulse,
    input  logic               result,
    input  logic               result_valid,
    output logic               start,
    output logic               load_colour,
    output logic               load_speed,
    output logic               rst_seedgen,
    output logic               player_turn,
    output logic               flash_clk,
    output logic [RW-1:0]      check_round,
    output logic [SPEED_W-1:0] speed,
    output logic               win,
    output logic               lose
);

    localparam int unsigned TW = $clog2(TIMEOUT_PULSES + 1);
    localparam int unsigned RampDiv = (RAMP_EVERY == 0) ? 1 : RAMP_EVERY;
    localparam logic [RW-1:0] MaxRound = RW'(MAX_ROUNDS);
    localparam logic [TW-1:0] TmoLimit = TW'(TIMEOUT_PULSES);
    localparam logic [SPEED_W-1:0] SpeedStart = SPEED_W'(SPEED_START);

    typedef enum logic [3:0] {
        StIdle, StSeed, StLoad, StReplay, StShow, StPlayer, StCheck, StAdvance, StWin, StLose
    } state_e;

    state_e             state_q, state_d;
    logic [RW-1:0]      r_q, r_d;
    logic [RW-1:0]      idx_q, idx_d;
    logic [TW-1:0]      tmo_q, tmo_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic               flash_q, flash_d;
    logic               load_colour_d;
    logic               start_q, load_colour_q, load_speed_q, rst_seedgen_q;
    logic               last_elem;
    logic               ramp_due;

    // idx is the element being shown or entered; the last one closes the sequence.
    assign last_elem = (idx_q + RW'(1)) == r_q;
    // r_q is the round just completed when evaluated in ADVANCE.
    assign ramp_due = (RAMP_EVERY != 0) && ((32'(r_q) % RampDiv) == 0) && (speed_q != '1);

    always_comb begin
        state_d       = state_q;
        r_d           = r_q;
        idx_d         = idx_q;
        tmo_d         = tmo_q;
        speed_d       = speed_q;
        flash_d       = flash_q;
        load_colour_d = 1'b0;
        unique case (state_q)
            StIdle, StWin, StLose: begin
                if (go) state_d = StSeed;
            end
            StSeed: begin
                r_d     = RW'(1);
                idx_d   = '0;
                tmo_d   = '0;
                speed_d = SpeedStart;
                flash_d = 1'b0;
                state_d = StLoad;
            end
            StLoad: state_d = StReplay;
            StReplay: begin
                idx_d         = '0;
                flash_d       = 1'b1;
                load_colour_d = 1'b1;
                state_d       = StShow;
            end
            StShow: begin
                if (pulse) begin
                    if (flash_q) begin
                        flash_d = 1'b0;
                    end else if (last_elem) begin
                        idx_d   = '0;
                        tmo_d   = '0;
                        state_d = StPlayer;
                    end else begin
                        idx_d         = idx_q + RW'(1);
                        flash_d       = 1'b1;
                        load_colour_d = 1'b1;
                    end
                end
            end
            StPlayer: begin
                // A press coincident with the final timeout pulse still counts.
                if (btn_press) begin
                    tmo_d   = '0;
                    state_d = StCheck;
                end else if (pulse) begin
                    tmo_d = tmo_q + TW'(1);
                    if ((tmo_q + TW'(1)) == TmoLimit) state_d = StLose;
                end
            end
            StCheck: begin
                if (result_valid) begin
                    if (!result) begin
                        state_d = StLose;
                    end else if (last_elem) begin
                        state_d = StAdvance;
                    end else begin
                        idx_d   = idx_q + RW'(1);
                        state_d = StPlayer;
                    end
                end
            end
            StAdvance: begin
                if (r_q == MaxRound) begin
                    state_d = StWin;
                end else begin
                    r_d = r_q + RW'(1);
                    if (ramp_due) begin
                        speed_d = speed_q + SPEED_W'(1);
                        state_d = StLoad;
                    end else begin
                        state_d = StReplay;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            r_q           <= '0;
            idx_q         <= '0;
            tmo_q         <= '0;
            speed_q       <= SpeedStart;
            flash_q       <= 1'b0;
            start_q       <= 1'b0;
            load_colour_q <= 1'b0;
            load_speed_q  <= 1'b0;
            rst_seedgen_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            r_q           <= r_d;
            idx_q         <= idx_d;
            tmo_q         <= tmo_d;
            speed_q       <= speed_d;
            flash_q       <= flash_d;
            // Strobes are registered so they coincide with the state they belong to.
            start_q       <= (state_d == StReplay);
            load_colour_q <= load_colour_d;
            load_speed_q  <= (state_d == StLoad);
            rst_seedgen_q <= (state_d == StSeed);
        end
    end

    always_comb begin
        check_round = '0;
        if (state_q == StShow) begin
            check_round = idx_q + RW'(1);
        end else if ((state_q == StPlayer) || (state_q == StCheck)) begin
            check_round = r_q;
        end
    end

    assign start       = start_q;
    assign load_colour = load_colour_q;
    assign load_speed  = load_speed_q;
    assign rst_seedgen = rst_seedgen_q;
    assign player_turn = (state_q == StPlayer) || (state_q == StCheck);
    assign flash_clk   = flash_q;
    assign speed       = speed_q;
    assign win         = (state_q == StWin);
    assign lose        = (state_q == StLose);

endmodule
